// File: rtl/iir_pkg.sv
// iir_pkg: coefficient addresses, commit-FSM encoding and default passthrough coefficients for iir_biquad_mc
package iir_pkg;
  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;
  localparam int N_COEF = 5;
  typedef enum logic {IDLE, PEND} commit_state_t;
  function automatic int default_coef(input int idx, input int frac);
    return idx == int'(COEF_B0) ? (1 << frac) : 0;
  endfunction
endpackage

// File: rtl/iir_biquad_mac.sv
// iir_biquad_mac: combinational 5-tap biquad MAC, arithmetic shift and output sat/wrap.
// Define IIR_SAT_EN to clamp out-of-range results; otherwise the low DATA_W bits are kept.
module iir_biquad_mac #(
  parameter int DATA_W = 9,
  parameter int COEF_W = 9,
  parameter int FRAC_BITS = 6
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [DATA_W-1:0] x2,
  input  logic signed [DATA_W-1:0] y1,
  input  logic signed [DATA_W-1:0] y2,
  input  logic signed [COEF_W-1:0] b0,
  input  logic signed [COEF_W-1:0] b1,
  input  logic signed [COEF_W-1:0] b2,
  input  logic signed [COEF_W-1:0] a1,
  input  logic signed [COEF_W-1:0] a2,
  output logic signed [DATA_W-1:0] y
);
  localparam int ACC_W = DATA_W + COEF_W + 3;
  logic signed [ACC_W-1:0] acc;
  // Operands are widened first so every product and the sum stay exact.
  always_comb acc = ACC_W'(b0) * ACC_W'(x) + ACC_W'(b1) * ACC_W'(x1) + ACC_W'(b2) * ACC_W'(x2)
                  - ACC_W'(a1) * ACC_W'(y1) - ACC_W'(a2) * ACC_W'(y2);
`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);
  logic signed [ACC_W-1:0] sh;
  always_comb begin
    sh = acc >>> FRAC_BITS;
    y = sh > MAX_V ? MAX_V[DATA_W-1:0] : sh < MIN_V ? MIN_V[DATA_W-1:0] : sh[DATA_W-1:0];
  end
`else
  always_comb y = DATA_W'(acc >>> FRAC_BITS);
`endif
endmodule

// File: rtl/iir_biquad_mc.sv
// iir_biquad_mc: time-multiplexed multichannel biquad with shadow coefficient bank committed on a sample boundary.
// IIR_SAT_EN (see iir_biquad_mac) selects saturating instead of wrapping output.
module iir_biquad_mc
  import iir_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int COEF_W = 9,
  parameter int FRAC_BITS = 6,
  parameter int N_CH = 4,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     vin,
  input  logic signed [DATA_W-1:0] din,
  input  logic [CH_W-1:0]          ch_in,
  input  logic                     coef_we,
  input  logic [2:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     coef_commit,
  input  logic                     state_clr,
  output logic                     cfg_pending,
  output logic                     vout,
  output logic signed [DATA_W-1:0] dout,
  output logic [CH_W-1:0]          ch_out
);
  logic s1_v;
  logic signed [DATA_W-1:0] s1_d;
  logic [CH_W-1:0] s1_ch;
  logic signed [COEF_W-1:0] shd [N_COEF];
  logic signed [COEF_W-1:0] act [N_COEF];
  logic signed [DATA_W-1:0] x1 [N_CH];
  logic signed [DATA_W-1:0] x2 [N_CH];
  logic signed [DATA_W-1:0] y1 [N_CH];
  logic signed [DATA_W-1:0] y2 [N_CH];
  logic signed [DATA_W-1:0] y;
  commit_state_t st, st_nx;
  logic copy;
  iir_biquad_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS)) mac (
    .x(s1_d), .x1(x1[s1_ch]), .x2(x2[s1_ch]), .y1(y1[s1_ch]), .y2(y2[s1_ch]),
    .b0(act[COEF_B0]), .b1(act[COEF_B1]), .b2(act[COEF_B2]), .a1(act[COEF_A1]), .a2(act[COEF_A2]),
    .y(y)
  );
  // Copy only when S1 is empty so no sample is ever computed across a coefficient change.
  always_comb begin
    copy = ~s1_v & (coef_commit | st == PEND);
    st_nx = s1_v & (coef_commit | st == PEND) ? PEND : IDLE;
  end
  assign cfg_pending = st == PEND;
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s1_d <= '0;
      s1_ch <= '0;
      vout <= 1'b0;
      dout <= '0;
      ch_out <= '0;
    end else begin
      s1_v <= vin & (int'(ch_in) < N_CH);
      s1_d <= din;
      s1_ch <= ch_in;
      vout <= s1_v;
      dout <= s1_v ? y : dout;
      ch_out <= s1_v ? s1_ch : ch_out;
    end
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else if (state_clr) begin
      for (int i = 0; i < N_CH; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else if (s1_v) begin
      x2[s1_ch] <= x1[s1_ch];
      x1[s1_ch] <= s1_d;
      y2[s1_ch] <= y1[s1_ch];
      y1[s1_ch] <= y;
    end
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      st <= IDLE;
      for (int i = 0; i < N_COEF; i++) begin
        shd[i] <= COEF_W'(default_coef(i, FRAC_BITS));
        act[i] <= COEF_W'(default_coef(i, FRAC_BITS));
      end
    end else begin
      st <= st_nx;
      if (coef_we && int'(coef_addr) < N_COEF) shd[coef_addr] <= coef_wdata;
      if (copy) for (int i = 0; i < N_COEF; i++) act[i] <= shd[i];
    end
endmodule

// File: tb/tb_iir_biquad_mc.sv
// tb_iir_biquad_mc: directed self-checking bench for iir_biquad_mc (honours IIR_SAT_EN like the RTL).
module tb_iir_biquad_mc;
  localparam int DW = 9;
  localparam int CW = 9;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic vin = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic [1:0] ch_in = '0;
  logic coef_we = 1'b0;
  logic [2:0] coef_addr = '0;
  logic signed [CW-1:0] coef_wdata = '0;
  logic coef_commit = 1'b0;
  logic state_clr = 1'b0;
  logic cfg_pending, vout;
  logic signed [DW-1:0] dout;
  logic [1:0] ch_out;
  int checks = 0;
  int errors = 0;
  int exp_imp [8] = '{64, 32, 16, 8, 4, 2, 1, 0};
`ifdef IIR_SAT_EN
  int exp_hi = 255;
  int exp_lo = -256;
`else
  int exp_hi = -6;
  int exp_lo = 4;
`endif
  always #5 clock = ~clock;
  iir_biquad_mc dut (
    .clock(clock), .rst(rst), .vin(vin), .din(din), .ch_in(ch_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .state_clr(state_clr), .cfg_pending(cfg_pending),
    .vout(vout), .dout(dout), .ch_out(ch_out)
  );
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic feed(input int ch, input int d, input logic v);
    vin = v;
    ch_in = 2'(ch);
    din = DW'(d);
    tick;
  endtask
  task automatic wcoef(input int addr, input int val);
    coef_we = 1'b1;
    coef_addr = 3'(addr);
    coef_wdata = CW'(val);
    tick;
    coef_we = 1'b0;
  endtask
  task automatic commit;
    coef_commit = 1'b1;
    tick;
    coef_commit = 1'b0;
  endtask
  task automatic clr;
    state_clr = 1'b1;
    tick;
    state_clr = 1'b0;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_vout", vout, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ch_out", ch_out, 0);
    chk("rst_pending", cfg_pending, 0);
    rst = 1'b0;
    feed(0, 64, 1);
    chk("t1_latency_vout", vout, 0);
    feed(2, -100, 1);
    chk("t1_vout", vout, 1);
    chk("t1_dout", dout, 64);
    chk("t1_ch_out", ch_out, 0);
    feed(0, 0, 0);
    chk("t1_dout_neg", dout, -100);
    chk("t1_ch_out2", ch_out, 2);
    feed(0, 0, 0);
    chk("t1_vout_low", vout, 0);
    wcoef(3, -32);
    commit;
    chk("t2_pending", cfg_pending, 0);
    clr;
    for (int i = 0; i < 9; i++) begin
      feed(1, i == 0 ? 64 : 0, i < 8);
      if (i > 0) begin
        chk($sformatf("t2_dout%0d", i - 1), dout, exp_imp[i-1]);
        chk($sformatf("t2_vout%0d", i - 1), vout, 1);
      end
    end
    clr;
    for (int i = 0; i < 17; i++) begin
      feed(i % 2, i < 2 ? 64 : 0, i < 16);
      if (i > 0) begin
        chk($sformatf("t3_dout%0d", i - 1), dout, 64 >> ((i - 1) / 2));
        chk($sformatf("t3_ch%0d", i - 1), ch_out, (i - 1) % 2);
      end
    end
    clr;
    wcoef(3, 0);
    for (int i = 0; i < 7; i++) begin
      coef_commit = i == 2;
      feed(2, i == 0 ? 64 : 0, 1);
      coef_commit = 1'b0;
      if (i > 0) chk($sformatf("t5_dout%0d", i - 1), dout, exp_imp[i-1]);
      if (i >= 2) chk($sformatf("t5_pending%0d", i), cfg_pending, 1);
    end
    feed(2, 0, 0);
    chk("t5_dout6", dout, exp_imp[6]);
    chk("t5_pending_gap", cfg_pending, 1);
    coef_we = 1'b1;
    coef_addr = 3'd0;
    coef_wdata = 9'sd32;
    feed(2, 100, 1);
    coef_we = 1'b0;
    chk("t5_pending_done", cfg_pending, 0);
    feed(2, 0, 0);
    chk("t5_new_set", dout, 100);
    commit;
    feed(2, 100, 1);
    feed(2, 0, 0);
    chk("t5_prewrite_shadow", dout, 50);
    wcoef(0, 127);
    commit;
    clr;
    feed(0, 255, 1);
    feed(0, -256, 1);
    chk("t4_hi", dout, exp_hi);
    feed(0, 0, 0);
    chk("t4_lo", dout, exp_lo);
    wcoef(0, 64);
    wcoef(3, -32);
    commit;
    clr;
    feed(1, 64, 1);
    feed(1, 0, 1);
    chk("t6_dout0", dout, 64);
    feed(1, 0, 1);
    chk("t6_dout1", dout, 32);
    rst = 1'b1;
    #1;
    chk("t6_rst_vout", vout, 0);
    chk("t6_rst_dout", dout, 0);
    vin = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("t6_flushed", vout, 0);
    feed(1, 64, 1);
    feed(1, 0, 1);
    chk("t6_pass0", dout, 64);
    feed(1, 0, 0);
    chk("t6_pass1", dout, 0);
    chk("t6_pending", cfg_pending, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
